// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: two-master Wishbone arbiter (SERV ibus/dbus) in front of the SPI memory controller.
// Each ack is followed by a forced cyc-low cycle so the controller sees a clean idle.
module spi_mem_arbiter #(
    parameter int ADR_W      = 14,
    parameter bit DBUS_PRIO  = 1'b1,
    parameter int MAX_CONSEC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cyc,
    input  logic [ADR_W-1:0] i_adr,
    output logic [31:0]      i_rdat,
    output logic             i_ack,
    input  logic             d_cyc,
    input  logic [ADR_W-1:0] d_adr,
    input  logic             d_we,
    input  logic [31:0]      d_wdat,
    input  logic [3:0]       d_sel,
    output logic [31:0]      d_rdat,
    output logic             d_ack,
    output logic             s_cyc,
    output logic [ADR_W-1:0] s_adr,
    output logic             s_we,
    output logic [31:0]      s_wdat,
    output logic [3:0]       s_sel,
    input  logic [31:0]      s_rdat,
    input  logic             s_ack,
    output logic [1:0]       grant
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    localparam logic [3:0] MAX = 4'(MAX_CONSEC);

    state_t     state;
    logic [3:0] cnt;
    logic       both;
    logic       starve;
    logic       pick_d;

    assign both   = i_cyc & d_cyc;
    assign starve = cnt >= MAX;
    // Under contention the priority master wins until it has had MAX grants in a row.
    assign pick_d = d_cyc & (~i_cyc | (DBUS_PRIO ? ~starve : starve));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: if (i_cyc | d_cyc) begin
                    state <= pick_d ? BUSY_D : BUSY_I;
                    grant <= pick_d ? 2'b10 : 2'b01;
                    cnt   <= (both && pick_d == DBUS_PRIO) ? cnt + {3'd0, cnt != 4'hf} : 4'd0;
                end
                BUSY_I, BUSY_D: if (s_ack) begin
                    state <= RELEASE;
                    grant <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Abandoned cycles still run to the slave ack; gating with cyc swallows that ack.
    assign s_cyc  = |grant;
    assign s_adr  = grant[1] ? d_adr : i_adr;
    assign s_we   = grant[1] & d_we;
    assign s_wdat = grant[1] ? d_wdat : 32'd0;
    assign s_sel  = grant[1] ? d_sel : 4'b1111;
    assign i_ack  = grant[0] & s_ack & i_cyc;
    assign d_ack  = grant[1] & s_ack & d_cyc;
    assign i_rdat = s_rdat;
    assign d_rdat = s_rdat;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed self-checking bench for spi_mem_arbiter (DBUS_PRIO=1, MAX_CONSEC=4).
module tb_spi_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_cyc, d_cyc, d_we, s_ack;
    logic [13:0] i_adr, d_adr, s_adr;
    logic [31:0] i_rdat, d_rdat, d_wdat, s_wdat, s_rdat;
    logic [3:0]  d_sel, s_sel;
    logic        i_ack, d_ack, s_cyc, s_we;
    logic [1:0]  grant;
    int          checks = 0;
    int          errors = 0;

    spi_mem_arbiter #(.ADR_W(14), .DBUS_PRIO(1'b1), .MAX_CONSEC(4)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_adr(i_adr), .i_rdat(i_rdat), .i_ack(i_ack),
        .d_cyc(d_cyc), .d_adr(d_adr), .d_we(d_we), .d_wdat(d_wdat), .d_sel(d_sel),
        .d_rdat(d_rdat), .d_ack(d_ack),
        .s_cyc(s_cyc), .s_adr(s_adr), .s_we(s_we), .s_wdat(s_wdat), .s_sel(s_sel),
        .s_rdat(s_rdat), .s_ack(s_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_cyc = 0; d_cyc = 0; d_we = 0; s_ack = 0;
        i_adr = 0; d_adr = 0; d_wdat = 0; d_sel = 0; s_rdat = 0;
        tick(); tick();
        chk("rst_scyc", 32'(s_cyc), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 0);
        chk("rst_we", 32'(s_we), 0);
        rst = 1'b0;
        tick();
        s_ack = 1'b1; #1;
        chk("idle_ack_ignored", {30'd0, i_ack, d_ack}, 0);
        s_ack = 1'b0;

        // ibus read, slave acks in the 3rd busy cycle, then back-to-back re-request
        i_cyc = 1'b1; i_adr = 14'h0010;
        tick();
        chk("i_scyc", 32'(s_cyc), 1);
        chk("i_grant", 32'(grant), 32'b01);
        chk("i_adr", 32'(s_adr), 32'h10);
        chk("i_sel_we", {27'd0, s_sel, s_we}, 32'b11110);
        chk("i_wdat", s_wdat, 0);
        tick(); tick();
        chk("i_hold", 32'(s_cyc), 1);
        s_ack = 1'b1; s_rdat = 32'hDEADBEEF; #1;
        chk("i_ack", {30'd0, i_ack, d_ack}, 32'b10);
        chk("i_rdat", i_rdat, 32'hDEADBEEF);
        chk("d_rdat", d_rdat, 32'hDEADBEEF);
        tick();
        s_ack = 1'b0; #1;
        chk("b2b_a1", {29'd0, s_cyc, grant}, 0);
        chk("b2b_a1_ack", 32'(i_ack), 0);
        tick();
        chk("b2b_a2", 32'(s_cyc), 0);
        tick();
        chk("b2b_a3", {29'd0, s_cyc, grant}, 32'b101);
        d_cyc = 1'b1; s_ack = 1'b1; #1;
        chk("i_owner_no_dack", {30'd0, i_ack, d_ack}, 32'b10);
        tick();
        s_ack = 1'b0; i_cyc = 1'b0; d_cyc = 1'b0;
        tick();

        // dbus write
        d_cyc = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_wdat = 32'h12345678; d_adr = 14'h0123;
        tick();
        chk("d_grant", 32'(grant), 32'b10);
        chk("d_adr", 32'(s_adr), 32'h123);
        chk("d_we_sel", {27'd0, s_sel, s_we}, 32'b00111);
        chk("d_wdat", s_wdat, 32'h12345678);
        chk("d_noack", 32'(d_ack), 0);
        tick();
        s_ack = 1'b1; #1;
        chk("d_ack", {30'd0, i_ack, d_ack}, 32'b01);
        tick();
        s_ack = 1'b0; d_cyc = 1'b0; d_we = 1'b0;
        tick();

        // contention: 4 dbus grants then 1 ibus, twice over (counter must clear)
        i_cyc = 1'b1; d_cyc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [1:0] exp_g;
            exp_g = (k == 4 || k == 9) ? 2'b01 : 2'b10;
            tick();
            chk($sformatf("arb_grant%0d", k), 32'(grant), 32'(exp_g));
            s_ack = 1'b1; #1;
            chk($sformatf("arb_ack%0d", k), {30'd0, i_ack, d_ack}, {30'd0, exp_g[0], exp_g[1]});
            tick();
            s_ack = 1'b0;
            tick();
        end
        i_cyc = 1'b0; d_cyc = 1'b0;
        tick();

        // dbus abort two cycles into the transfer
        d_cyc = 1'b1;
        tick();
        chk("ab_grant", 32'(grant), 32'b10);
        tick(); tick();
        d_cyc = 1'b0;
        tick();
        chk("ab_hold", {29'd0, s_cyc, grant}, 32'b110);
        s_ack = 1'b1; #1;
        chk("ab_swallow", {30'd0, i_ack, d_ack}, 0);
        tick();
        s_ack = 1'b0; #1;
        chk("ab_release", 32'(s_cyc), 0);
        tick();
        chk("ab_idle", 32'(s_cyc), 0);

        // asynchronous reset mid ibus transfer
        i_cyc = 1'b1;
        tick();
        chk("r_busy", 32'(grant), 32'b01);
        s_ack = 1'b1; #1;
        rst = 1'b1; #1;
        chk("r_async", {28'd0, s_cyc, grant, i_ack}, 0);
        s_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("r_regrant", {29'd0, s_cyc, grant}, 32'b101);
        s_ack = 1'b1; #1;
        chk("r_ack", 32'(i_ack), 1);
        tick();
        s_ack = 1'b0; i_cyc = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Two-master Wishbone arbiter that shares the single SPI memory controller between the SERV instruction bus (read-only) and data bus. It sits between the core's ibus/dbus and the SPI memory controller's Wishbone slave port. It serialises accesses and inserts the mandatory cyc-low release cycle after each ack, because the controller restarts on any cyc seen in its idle state. A starvation guard bounds consecutive grants to the priority master.

Parameters:
ADR_W, 14, word-address width on all ports
DBUS_PRIO, 1, 1 = dbus wins simultaneous requests; 0 = ibus wins
MAX_CONSEC, 4, max back-to-back grants to the priority master while the other master waits (1..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
i_cyc  input  1  ibus cycle request
i_adr  input  ADR_W  ibus word address
i_rdat  output  32  ibus read data
i_ack  output  1  ibus acknowledge
d_cyc  input  1  dbus cycle request
d_adr  input  ADR_W  dbus word address
d_we  input  1  dbus write enable
d_wdat  input  32  dbus write data
d_sel  input  4  dbus byte select
d_rdat  output  32  dbus read data
d_ack  output  1  dbus acknowledge
s_cyc  output  1  cycle to memory controller
s_adr  output  ADR_W  address to controller
s_we  output  1  write enable to controller
s_wdat  output  32  write data to controller
s_sel  output  4  byte select to controller
s_rdat  input  32  read data from controller
s_ack  input  1  ack from controller
grant  output  2  status: bit0 = ibus owns the bus, bit1 = dbus owns the bus

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, RELEASE. The state register is asynchronously reset to IDLE; the consecutive-grant counter is reset to 0.
- Reset values: s_cyc=0, s_we=0, i_ack=0, d_ack=0, grant=00.
- IDLE: arbitrate on i_cyc/d_cyc sampled this cycle.
  - Only one master requesting: go to its BUSY state.
  - Both requesting: grant the priority master unless cnt >= MAX_CONSEC, in which case grant the other master.
  - Neither requesting: stay in IDLE.
- Latency: a request seen in IDLE at cycle N gives s_cyc=1 at cycle N+1.
- BUSY_x:
  - s_cyc=1 and grant reflects the owner.
  - s_adr, s_we, s_wdat and s_sel are combinationally muxed from the owner's live signals.
  - The Wishbone rule applies: masters hold their signals until ack.
  - For ibus: s_we=0, s_sel=4'b1111, s_wdat=0.
  - On s_ack=1: assert the owner's ack combinationally in the same cycle, gated by the owner's cyc; the next state is RELEASE.
- i_rdat and d_rdat both carry s_rdat at all times. Only the ack is steered.
- The non-owner's ack is always 0. A slave ack in IDLE or RELEASE is ignored.
- RELEASE: s_cyc=0 and grant=00 for exactly one cycle, then IDLE. No arbitration happens in RELEASE.
- Min gap: ack at cycle A means the next s_cyc rises at A+3 at the earliest (RELEASE, IDLE, BUSY).
- Starvation counter cnt (4 bits):
  - On entering the priority master's BUSY state while the other master was also requesting: cnt <= cnt+1.
  - On granting the non-priority master: cnt <= 0.
  - On granting the priority master with no competing request: cnt <= 0.
  - cnt saturates at 15.
- Owner drops cyc before s_ack (abort):
  - Stay in BUSY with s_cyc=1 until s_ack, because the controller cannot abort mid-transfer.
  - Swallow that ack (no i_ack/d_ack), then go to RELEASE as normal.
- No timeout: a missing s_ack holds BUSY indefinitely.
- rst asserted mid-transaction: immediately return to IDLE with s_cyc=0. The controller has its own reset.
- grant is one-hot or 00, never 11.

Test Plan:
- ibus only: i_cyc=1, i_adr=0x0010, slave acks 3 cycles after s_cyc with s_rdat=0xDEADBEEF -> s_adr=0x0010, s_sel=1111, s_we=0; i_ack one cycle with i_rdat=0xDEADBEEF; s_cyc=0 for one cycle after ack; d_ack never asserted.
- dbus write: d_cyc=1, d_we=1, d_sel=0011, d_wdat=0x12345678, d_adr=0x0123 -> slave sees identical values; d_ack coincides with s_ack; grant=10 during the transfer.
- Simultaneous requests with DBUS_PRIO=1, MAX_CONSEC=4, both cyc held high, ibus re-requesting after each ack -> 4 dbus grants, then 1 ibus grant, then dbus again; cnt returns to 0 after the ibus grant.
- Back-to-back: s_ack at cycle A with i_cyc re-asserted at A+1 -> s_cyc=0 at A+1 and A+2; s_cyc=1 again at A+3.
- Abort: d_cyc drops 2 cycles into BUSY_D -> s_cyc stays 1 until s_ack; d_ack stays 0; then RELEASE and IDLE.
- Reset mid-BUSY_I: rst=1 asynchronously -> s_cyc=0, grant=00 and i_ack=0 immediately; after release, a fresh i_cyc is granted normally.
